// File: rtl/sprite_bounce_if.sv
// sprite_bounce_if
//  Connects the frame timing side (frame strobe, motion enable) to the sprite
//  motion scheduler and carries the committed sprite state back out.
//  master : frame/video side. Drives frame_tick and enable, and reads the sprite state.
//  slave  : sprite_bounce_ctrl. Reads frame_tick and enable, and drives the sprite state.
//  Signals:
//   frame_tick   1   one-cycle strobe per frame (vertical blanking)
//   enable       1   motion enable
//   sprite_x     10  sprite left edge
//   sprite_y     9   sprite top edge
//   dir_x/dir_y  1   1 = right / down
//   palette_idx  3   colour index, advances on each bounce
//   bounce       1   one-cycle pulse, at least one axis reflected
//   corner       1   one-cycle pulse, both axes reflected
//   busy         1   scheduler mid-update
interface sprite_bounce_if;
    logic       frame_tick;
    logic       enable;
    logic [9:0] sprite_x;
    logic [8:0] sprite_y;
    logic       dir_x;
    logic       dir_y;
    logic [2:0] palette_idx;
    logic       bounce;
    logic       corner;
    logic       busy;

    modport master (
        output frame_tick, enable,
        input  sprite_x, sprite_y, dir_x, dir_y, palette_idx, bounce, corner, busy
    );

    modport slave (
        input  frame_tick, enable,
        output sprite_x, sprite_y, dir_x, dir_y, palette_idx, bounce, corner, busy
    );
endinterface

// File: rtl/sprite_bounce_ctrl.sv
// sprite_bounce_ctrl
//  Motion scheduler for the screensaver sprite. On every FRAME_DIV-th enabled
//  frame tick, it moves the top-left corner by STEP pixels on each axis.
//  Direction reverses at the screen edges.
//  The palette index advances once for each update that bounces.
//  The new position, the directions and the pulses all appear on the same clock edge.
//  Ports:
//   clk_25_175  in   pixel clock
//   rst         in   asynchronous, active-high reset
//   sb          slave modport of sprite_bounce_if (frame_tick/enable in,
//               sprite state, bounce/corner pulses and busy out)
//
//  state  | meaning
//  -------+----------------------------------------------------------
//  IDLE   | waiting for a qualifying frame tick; divides ticks
//  CALC_X | compute next x and whether the x axis reflects
//  CALC_Y | compute next y and whether the y axis reflects
//  COMMIT | load position/direction/palette, fire pulses on exit
module sprite_bounce_ctrl #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int SPRITE_W  = 64,
    parameter int SPRITE_H  = 32,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1
) (
    input logic            clk_25_175,
    input logic            rst,
    sprite_bounce_if.slave sb
);

    // Edge tests use 11-bit arithmetic so that x+STEP cannot wrap.
    localparam logic [10:0] MAX_X    = 11'(SCREEN_W - SPRITE_W);
    localparam logic [10:0] MAX_Y    = 11'(SCREEN_H - SPRITE_H);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [9:0]  MAX_X10  = 10'(SCREEN_W - SPRITE_W);
    localparam logic [8:0]  MAX_Y9   = 9'(SCREEN_H - SPRITE_H);
    localparam logic [9:0]  STEP_X   = 10'(STEP);
    localparam logic [8:0]  STEP_Y   = 9'(STEP);
    localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_X = 2'd1,
        CALC_Y = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t     state_q, state_d;

    logic [7:0] div_cnt_q, div_cnt_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       dx_q, dx_d;
    logic       dy_q, dy_d;
    logic [2:0] pal_q, pal_d;
    logic       bounce_q, bounce_d;
    logic       corner_q, corner_d;
    logic       busy_q, busy_d;

    // Staged results, held until COMMIT so the visible state changes at once.
    logic [9:0] nx_q, nx_d;
    logic [8:0] ny_q, ny_d;
    logic       flip_x_q, flip_x_d;
    logic       flip_y_q, flip_y_d;

    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic        any_flip;

    assign x_ext    = {1'b0, x_q};
    assign y_ext    = {2'b00, y_q};
    assign any_flip = flip_x_q | flip_y_q;

    always_ff @(posedge clk_25_175 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        pal_d     = pal_q;
        bounce_d  = 1'b0;
        corner_d  = 1'b0;
        nx_d      = nx_q;
        ny_d      = ny_q;
        flip_x_d  = flip_x_q;
        flip_y_d  = flip_y_q;

        case (state_q)
            IDLE: begin
                // Ticks that arrive while an update is in flight never get here.
                // That is why they are neither counted nor queued.
                if (sb.frame_tick && sb.enable) begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d = '0;
                        state_d   = CALC_X;
                    end else begin
                        div_cnt_d = div_cnt_q + 8'd1;
                    end
                end
            end

            CALC_X: begin
                flip_x_d = 1'b0;
                if (dx_q) begin
                    if (x_ext + STEP_W >= MAX_X) begin
                        nx_d     = MAX_X10;
                        flip_x_d = 1'b1;
                    end else begin
                        nx_d = x_q + STEP_X;
                    end
                end else begin
                    if (x_ext <= STEP_W) begin
                        nx_d     = '0;
                        flip_x_d = 1'b1;
                    end else begin
                        nx_d = x_q - STEP_X;
                    end
                end
                state_d = CALC_Y;
            end

            CALC_Y: begin
                flip_y_d = 1'b0;
                if (dy_q) begin
                    if (y_ext + STEP_W >= MAX_Y) begin
                        ny_d     = MAX_Y9;
                        flip_y_d = 1'b1;
                    end else begin
                        ny_d = y_q + STEP_Y;
                    end
                end else begin
                    if (y_ext <= STEP_W) begin
                        ny_d     = '0;
                        flip_y_d = 1'b1;
                    end else begin
                        ny_d = y_q - STEP_Y;
                    end
                end
                state_d = COMMIT;
            end

            COMMIT: begin
                x_d      = nx_q;
                y_d      = ny_q;
                dx_d     = dx_q ^ flip_x_q;
                dy_d     = dy_q ^ flip_y_q;
                // A corner hit counts as a single bounce for the palette.
                pal_d    = pal_q + {2'b00, any_flip};
                bounce_d = any_flip;
                corner_d = flip_x_q & flip_y_q;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_25_175 or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            pal_q     <= '0;
            bounce_q  <= 1'b0;
            corner_q  <= 1'b0;
            busy_q    <= 1'b0;
            nx_q      <= '0;
            ny_q      <= '0;
            flip_x_q  <= 1'b0;
            flip_y_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            pal_q     <= pal_d;
            bounce_q  <= bounce_d;
            corner_q  <= corner_d;
            busy_q    <= busy_d;
            nx_q      <= nx_d;
            ny_q      <= ny_d;
            flip_x_q  <= flip_x_d;
            flip_y_q  <= flip_y_d;
        end
    end

    assign sb.sprite_x    = x_q;
    assign sb.sprite_y    = y_q;
    assign sb.dir_x       = dx_q;
    assign sb.dir_y       = dy_q;
    assign sb.palette_idx = pal_q;
    assign sb.bounce      = bounce_q;
    assign sb.corner      = corner_q;
    assign sb.busy        = busy_q;

endmodule

// File: tb/tb_sprite_bounce_ctrl.sv
module tb_sprite_bounce_ctrl;

    localparam int STEP = 2;
    localparam int MAXX = 576;
    localparam int MAXY = 448;

    logic clk_25_175 = 1'b0;
    logic rst;

    always #20 clk_25_175 = ~clk_25_175;

    sprite_bounce_if sb_a();
    sprite_bounce_if sb_b();

    sprite_bounce_ctrl #(.FRAME_DIV(1)) dut_a (
        .clk_25_175 (clk_25_175),
        .rst        (rst),
        .sb         (sb_a)
    );

    sprite_bounce_ctrl #(.FRAME_DIV(3)) dut_b (
        .clk_25_175 (clk_25_175),
        .rst        (rst),
        .sb         (sb_b)
    );

    typedef struct {
        int x;
        int y;
        bit dx;
        bit dy;
        int pal;
    } pos_t;

    typedef struct {
        pos_t p;
        bit   bounce;
        bit   corner;
    } upd_t;

    typedef struct {
        int n_ticks;
        bit en;
        bit drop_en;
        int x;
        int y;
        bit dx;
        bit dy;
        int pal;
    } vec_t;

    localparam pos_t RESET_POS = '{x: 0, y: 0, dx: 1'b1, dy: 1'b1, pal: 0};

    upd_t exp_q[$];
    pos_t cur;
    pos_t mdl;
    int   mdl_div;
    bit   mon_on = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   bounce_seen = 0;
    int   corner_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_update(inout pos_t s, output bit b, output bit c);
        bit fx;
        bit fy;
        fx = 1'b0;
        fy = 1'b0;
        if (s.dx) begin
            if (s.x + STEP >= MAXX) begin s.x = MAXX; fx = 1'b1; end
            else s.x = s.x + STEP;
        end else begin
            if (s.x <= STEP) begin s.x = 0; fx = 1'b1; end
            else s.x = s.x - STEP;
        end
        if (s.dy) begin
            if (s.y + STEP >= MAXY) begin s.y = MAXY; fy = 1'b1; end
            else s.y = s.y + STEP;
        end else begin
            if (s.y <= STEP) begin s.y = 0; fy = 1'b1; end
            else s.y = s.y - STEP;
        end
        if (fx) s.dx = ~s.dx;
        if (fy) s.dy = ~s.dy;
        b = fx | fy;
        c = fx & fy;
        if (b) s.pal = (s.pal + 1) % 8;
    endfunction

    // Monitor for dut_a: outputs must hold the last committed state except on
    // the cycle after COMMIT (busy falling), where the scoreboard is popped.
    initial begin
        logic busy_prev;
        upd_t u;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk_25_175);
            if (mon_on) begin
                if (sb_a.bounce === 1'b1) bounce_seen++;
                if (sb_a.corner === 1'b1) corner_seen++;
                if (busy_prev && sb_a.busy === 1'b0 && !rst) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_commit: got an update, expected none pending");
                    end else begin
                        u = exp_q.pop_front();
                        cur = u.p;
                        check("sb_bounce", sb_a.bounce, int'(u.bounce));
                        check("sb_corner", sb_a.corner, int'(u.corner));
                    end
                end else begin
                    check("idle_bounce", sb_a.bounce, 0);
                    check("idle_corner", sb_a.corner, 0);
                end
                check("mon_x",   sb_a.sprite_x,    cur.x);
                check("mon_y",   sb_a.sprite_y,    cur.y);
                check("mon_dx",  sb_a.dir_x,       int'(cur.dx));
                check("mon_dy",  sb_a.dir_y,       int'(cur.dy));
                check("mon_pal", sb_a.palette_idx, cur.pal);
            end
            busy_prev = sb_a.busy;
        end
    end

    task automatic tick_a(input bit en, input bit drop_en);
        bit qual;
        bit b;
        bit c;
        int nbusy;
        @(negedge clk_25_175);
        sb_a.enable     = en;
        sb_a.frame_tick = 1'b1;
        qual = 1'b0;
        if (en) begin
            if (mdl_div == 0) qual = 1'b1;   // FRAME_DIV = 1 on dut_a
        end
        if (qual) begin
            model_update(mdl, b, c);
            exp_q.push_back('{p: mdl, bounce: b, corner: c});
        end
        @(negedge clk_25_175);
        sb_a.frame_tick = 1'b0;
        if (drop_en) sb_a.enable = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk_25_175);
            if (sb_a.busy === 1'b1) nbusy++;
        end
        check("busy_cycles_a", nbusy, qual ? 3 : 0);
    endtask

    task automatic tick_b(input string name, input int exp_busy);
        int nbusy;
        @(negedge clk_25_175);
        sb_b.enable     = 1'b1;
        sb_b.frame_tick = 1'b1;
        @(negedge clk_25_175);
        sb_b.frame_tick = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk_25_175);
            if (sb_b.busy === 1'b1) nbusy++;
        end
        check(name, nbusy, exp_busy);
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];

    initial begin
        vecs[0] = '{n_ticks: 3,    en: 0, drop_en: 0, x: 0,   y: 0,   dx: 1, dy: 1, pal: 0};
        vecs[1] = '{n_ticks: 1,    en: 1, drop_en: 1, x: 2,   y: 2,   dx: 1, dy: 1, pal: 0};
        vecs[2] = '{n_ticks: 286,  en: 1, drop_en: 0, x: 574, y: 322, dx: 1, dy: 0, pal: 1};
        vecs[3] = '{n_ticks: 1,    en: 1, drop_en: 0, x: 576, y: 320, dx: 0, dy: 0, pal: 2};
        vecs[4] = '{n_ticks: 1,    en: 1, drop_en: 0, x: 574, y: 318, dx: 0, dy: 0, pal: 2};
        vecs[5] = '{n_ticks: 1727, en: 1, drop_en: 0, x: 576, y: 448, dx: 0, dy: 0, pal: 7};
        vecs[6] = '{n_ticks: 1,    en: 1, drop_en: 0, x: 574, y: 446, dx: 0, dy: 0, pal: 7};
        vecs[7] = '{n_ticks: 223,  en: 1, drop_en: 0, x: 128, y: 0,   dx: 0, dy: 1, pal: 0};

        rst = 1'b1;
        sb_a.frame_tick = 1'b0;
        sb_a.enable     = 1'b0;
        sb_b.frame_tick = 1'b0;
        sb_b.enable     = 1'b0;
        cur     = RESET_POS;
        mdl     = RESET_POS;
        mdl_div = 0;
        repeat (3) @(negedge clk_25_175);
        rst = 1'b0;

        check("rst_x",      sb_a.sprite_x,    0);
        check("rst_y",      sb_a.sprite_y,    0);
        check("rst_dx",     sb_a.dir_x,       1);
        check("rst_dy",     sb_a.dir_y,       1);
        check("rst_pal",    sb_a.palette_idx, 0);
        check("rst_busy",   sb_a.busy,        0);
        check("rst_bounce", sb_a.bounce,      0);
        check("rst_corner", sb_a.corner,      0);
        mon_on = 1'b1;

        for (int v = 0; v < 8; v++) begin
            for (int t = 0; t < vecs[v].n_ticks; t++) tick_a(vecs[v].en, vecs[v].drop_en);
            check($sformatf("vec%0d_x", v),   sb_a.sprite_x,    vecs[v].x);
            check($sformatf("vec%0d_y", v),   sb_a.sprite_y,    vecs[v].y);
            check($sformatf("vec%0d_dx", v),  sb_a.dir_x,       int'(vecs[v].dx));
            check($sformatf("vec%0d_dy", v),  sb_a.dir_y,       int'(vecs[v].dy));
            check($sformatf("vec%0d_pal", v), sb_a.palette_idx, vecs[v].pal);
        end
        check("sb_drained",    exp_q.size(), 0);
        check("bounce_pulses", bounce_seen,  16);
        check("corner_pulses", corner_seen,  1);

        // FRAME_DIV = 3: updates on the 3rd and 6th ticks only.
        tick_b("div_t1", 0);
        tick_b("div_t2", 0);
        tick_b("div_t3", 3);
        check("div_x_after3", sb_b.sprite_x, 2);
        tick_b("div_t4", 0);
        tick_b("div_t5", 0);
        tick_b("div_t6", 3);
        check("div_x_after6", sb_b.sprite_x, 4);
        check("div_y_after6", sb_b.sprite_y, 4);

        // Reset while dut_a sits in CALC_Y: nothing of the update may survive.
        @(negedge clk_25_175);
        sb_a.enable     = 1'b1;
        sb_a.frame_tick = 1'b1;
        @(negedge clk_25_175);
        sb_a.frame_tick = 1'b0;
        @(negedge clk_25_175);
        check("busy_before_rst", sb_a.busy, 1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        cur     = RESET_POS;
        mdl     = RESET_POS;
        mdl_div = 0;
        #2;
        check("midrst_x",    sb_a.sprite_x,    0);
        check("midrst_y",    sb_a.sprite_y,    0);
        check("midrst_dx",   sb_a.dir_x,       1);
        check("midrst_dy",   sb_a.dir_y,       1);
        check("midrst_pal",  sb_a.palette_idx, 0);
        check("midrst_busy", sb_a.busy,        0);
        repeat (2) @(negedge clk_25_175);
        rst = 1'b0;
        repeat (8) @(negedge clk_25_175);
        check("postrst_x",    sb_a.sprite_x, 0);
        check("postrst_busy", sb_a.busy,     0);

        // dut_b after reset: a tick during busy must not advance the divider.
        tick_b("ign_t1", 0);
        tick_b("ign_t2", 0);
        @(negedge clk_25_175);
        sb_b.frame_tick = 1'b1;
        @(negedge clk_25_175);
        sb_b.frame_tick = 1'b1;
        check("ign_busy", sb_b.busy, 1);
        @(negedge clk_25_175);
        sb_b.frame_tick = 1'b0;
        repeat (4) @(negedge clk_25_175);
        check("ign_x_first", sb_b.sprite_x, 2);
        check("ign_busy_idle", sb_b.busy, 0);
        tick_b("ign_t4", 0);
        tick_b("ign_t5", 0);
        tick_b("ign_t6", 3);
        check("ign_x_second", sb_b.sprite_x, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
